bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, 4, number of cache requesters (fixed at 4 for this release).
REQ-002 Parameters SHALL be: ADDR_W, 8, block address width.
REQ-003 Parameters SHALL be: WB_CYCLES, 2, write-back cycles; legal range 1..15.
REQ-004 Ports SHALL be: clock  in  1  single clock; all logic on rising edge.
REQ-005 Ports SHALL be: reset  in  1  synchronous, active-high reset.
REQ-006 Ports SHALL be: req  in  N_REQ  per-cache bus request, held until its done pulse.
REQ-007 Ports SHALL be: msgReq  in  3*N_REQ  per-cache bus message, slice i = bits [3i+2:3i].
REQ-008 Ports SHALL be: addrReq  in  ADDR_W*N_REQ  per-cache block address, slice i likewise.
REQ-009 Ports SHALL be: writeBack  in  N_REQ  per-cache snoop write-back indication.
REQ-010 Ports SHALL be: grant  out  N_REQ  one-hot bus owner; all-zero when idle.
REQ-011 Ports SHALL be: mensagemBus  out  3  broadcast message; 000 = no message.
REQ-012 Ports SHALL be: addrBus  out  ADDR_W  broadcast address.
REQ-013 Ports SHALL be: wbActive  out  1  write-back in progress.
REQ-014 Ports SHALL be: done  out  N_REQ  one-cycle completion pulse to the owner.

Function
REQ-015 Legal messages SHALL be WRITE_MISS 001, READ_MISS 010, INVALIDATE 011; a req with message 000 or 100..111 SHALL be ineligible and never granted.
REQ-016 FSM states SHALL be IDLE, BROADCAST, SNOOP, WRITEBACK, DONE.
REQ-017 IDLE: grant=0, mensagemBus=000, addrBus=0; on an edge with any eligible req, latch winner, message and address; go to BROADCAST.
REQ-018 Winner SHALL be the first eligible requester scanning from priority pointer ptr upward modulo N_REQ.
REQ-019 BROADCAST (exactly 1 cycle): grant=one-hot winner, mensagemBus and addrBus = latched values; go to SNOOP.
REQ-020 SNOOP (exactly 1 cycle): grant held, mensagemBus=000, addrBus held; at the edge sample writeBack with the owner bit masked; any set -> WRITEBACK, else -> DONE.
REQ-021 WRITEBACK: wbActive=1, grant held, exactly WB_CYCLES cycles via down-counter; then DONE.
REQ-022 DONE (exactly 1 cycle): done[owner]=1, grant held; ptr := (owner+1) mod N_REQ; go to IDLE.
REQ-023 Latency: from the accepting edge, done SHALL assert in cycle 3 without write-back and in cycle 3+WB_CYCLES with write-back.
REQ-024 At least one IDLE cycle SHALL separate consecutive transactions.
REQ-025 A req or input change after acceptance SHALL NOT affect the ongoing transaction; it completes with latched values.
REQ-026 writeBack outside the SNOOP sampling edge SHALL be ignored; writeBack after INVALIDATE SHALL be honoured identically.
REQ-027 Simultaneous eligible requests SHALL be resolved solely by REQ-018; no requester SHALL wait more than N_REQ-1 transactions.

Reset
REQ-028 When reset=1 at an edge: state=IDLE, ptr=0, counter=0, and grant, mensagemBus, addrBus, wbActive, done all 0 from the next cycle.
REQ-029 Reset mid-transaction SHALL abort it without a done pulse; reset SHALL take priority over all transitions.

Structure
REQ-030 Cache state codes (INVALID 00, SHARED 01, EXCLUSIVE 10) and bus message codes SHALL live in one shared definitions file used by this block and the snooping receivers.
REQ-031 FSM state encodings SHALL be local to bus_arbiter.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs eligible mask and ptr; output one-hot winner and valid).

Verification
REQ-033 Single request: req=0001, msg0=010, addr0=8'h3C, no writeBack -> BROADCAST shows mensagemBus=010/addrBus=3C/grant=0001; done=0001 in cycle 3.
REQ-034 Write-back: cache 1 WRITE_MISS addr 8'h10, writeBack[2]=1 during SNOOP -> wbActive for 2 cycles, done=0010 in cycle 5.
REQ-035 Fairness: req=1111 held continuously after each done -> grant order 0001,0010,0100,1000,0001.
REQ-036 Illegal message: req=0100 with msg2=000 or 111 -> grant stays 0, no done.
REQ-037 Reset in WRITEBACK -> next cycle all outputs 0, no done; after release req=0001 granted with ptr=0.
REQ-038 Owner self-writeBack: writeBack=0001 with cache 0 owner -> masked, done in cycle 3, wbActive never set.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared bus-protocol definitions: cache line states and snoopy bus message codes,
// used by the arbiter and by the snooping cache receivers.
package bus_arbiter_pkg;

    localparam int MSG_W = 3;

    typedef enum logic [1:0] {
        CACHE_INVALID   = 2'b00,
        CACHE_SHARED    = 2'b01,
        CACHE_EXCLUSIVE = 2'b10
    } cache_state_t;

    typedef enum logic [MSG_W-1:0] {
        MSG_NONE       = 3'b000,
        MSG_WRITE_MISS = 3'b001,
        MSG_READ_MISS  = 3'b010,
        MSG_INVALIDATE = 3'b011
    } bus_msg_t;

    function automatic logic is_legal_msg(input logic [MSG_W-1:0] msg);
        return (msg == MSG_WRITE_MISS) || (msg == MSG_READ_MISS) || (msg == MSG_INVALIDATE);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of the eligible mask at or above
// ptr, wrapping modulo N.
module rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             valid
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Snoopy-bus arbiter: grants one cache at a time, broadcasts its message, samples
// snoop write-back, optionally stalls for the write-back, then pulses done.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 8,
    parameter int WB_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [3*N_REQ-1:0]      msgReq,
    input  logic [ADDR_W*N_REQ-1:0] addrReq,
    input  logic [N_REQ-1:0]        writeBack,
    output logic [N_REQ-1:0]        grant,
    output logic [2:0]              mensagemBus,
    output logic [ADDR_W-1:0]       addrBus,
    output logic                    wbActive,
    output logic [N_REQ-1:0]        done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BROADCAST,
        S_SNOOP,
        S_WRITEBACK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    owner_q;
    logic [MSG_W-1:0]    msg_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    pick_winner;
    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [N_REQ-1:0]    owner_oh;
    logic                wb_hit;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req[i] && is_legal_msg(msgReq[3*i +: 3]);
        end
    end

    rr_picker #(.N(N_REQ), .PTR_W(PTR_W)) u_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .winner   (pick_winner),
        .valid    (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_winner[i]) pick_idx = PTR_W'(i);
        end
    end

    assign owner_oh = N_REQ'(1) << owner_q;
    // The owner never snoops its own transaction, so its write-back bit is ignored.
    assign wb_hit   = |(writeBack & ~owner_oh);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            msg_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        msg_q   <= msgReq[3*int'(pick_idx) +: 3];
                        addr_q  <= addrReq[ADDR_W*int'(pick_idx) +: ADDR_W];
                    end
                end
                S_SNOOP: begin
                    if (wb_hit) cnt_q <= CNT_W'(WB_CYCLES - 1);
                end
                S_WRITEBACK: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_DONE: begin
                    ptr_q <= (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        grant       = '0;
        mensagemBus = MSG_NONE;
        addrBus     = '0;
        wbActive    = 1'b0;
        done        = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) state_d = S_BROADCAST;
            end
            S_BROADCAST: begin
                grant       = owner_oh;
                mensagemBus = msg_q;
                addrBus     = addr_q;
                state_d     = S_SNOOP;
            end
            S_SNOOP: begin
                grant   = owner_oh;
                addrBus = addr_q;
                state_d = wb_hit ? S_WRITEBACK : S_DONE;
            end
            S_WRITEBACK: begin
                grant    = owner_oh;
                addrBus  = addr_q;
                wbActive = 1'b1;
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                grant   = owner_oh;
                addrBus = addr_q;
                done    = owner_oh;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected transactions, a
// monitor pops and compares each one when the DUT pulses done.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int WB = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [3*N-1:0]  msgReq;
    logic [AW*N-1:0] addrReq;
    logic [N-1:0]    writeBack;
    logic [N-1:0]    grant;
    logic [2:0]      mensagemBus;
    logic [AW-1:0]   addrBus;
    logic            wbActive;
    logic [N-1:0]    done;

    bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .WB_CYCLES(WB)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .msgReq      (msgReq),
        .addrReq     (addrReq),
        .writeBack   (writeBack),
        .grant       (grant),
        .mensagemBus (mensagemBus),
        .addrBus     (addrBus),
        .wbActive    (wbActive),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] grant;
        logic [2:0] msg;
        logic [7:0] addr;
        int         lat;
        int         wb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: captures the broadcast cycle, counts write-back cycles, compares on done.
    initial begin
        logic [3:0] prev_grant, bc_grant;
        logic [2:0] bc_msg;
        logic [7:0] bc_addr;
        int         bc_cyc, wb_cnt;
        exp_t       e;
        prev_grant = '0; bc_grant = '0; bc_msg = '0; bc_addr = '0;
        bc_cyc = 0; wb_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (grant != 0 && prev_grant == 0) begin
                    bc_grant = grant;
                    bc_msg   = mensagemBus;
                    bc_addr  = addrBus;
                    bc_cyc   = cyc;
                    wb_cnt   = 0;
                end
                if (wbActive) wb_cnt++;
                if (done != 0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_vec",   done,             e.grant);
                        check("bc_grant",   bc_grant,         e.grant);
                        check("bc_msg",     bc_msg,           e.msg);
                        check("bc_addr",    bc_addr,          e.addr);
                        check("latency",    cyc - bc_cyc + 1, e.lat);
                        check("wb_cycles",  wb_cnt,           e.wb);
                    end
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_cache(input int i, input logic [2:0] m, input logic [7:0] a);
        msgReq[3*i +: 3]   = m;
        addrReq[AW*i +: AW] = a;
    endtask

    task automatic push(input logic [3:0] g, input logic [2:0] m, input logic [7:0] a,
                        input int lat, input int wb);
        exp_t e;
        e.grant = g; e.msg = m; e.addr = a; e.lat = lat; e.wb = wb;
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},    grant,       0);
        check({tag, "_msg"},      mensagemBus, 0);
        check({tag, "_addr"},     addrBus,     0);
        check({tag, "_wbActive"}, wbActive,    0);
        check({tag, "_done"},     done,        0);
    endtask

    task automatic expect_no_grant(input string name, input int n);
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            seen |= grant;
        end
        check(name, seen, 0);
    endtask

    initial begin
        int k;
        reset = 1'b1; req = '0; msgReq = '0; addrReq = '0; writeBack = '0;
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b0;
        tick(1);

        // Single READ_MISS from cache 0.
        set_cache(0, 3'b010, 8'h3C);
        push(4'b0001, 3'b010, 8'h3C, 3, 0);
        req = 4'b0001;
        drain("t_single", 20);
        req = '0;

        // Cache 1 WRITE_MISS with snoop write-back from cache 2.
        set_cache(1, 3'b001, 8'h10);
        push(4'b0010, 3'b001, 8'h10, 3 + WB, WB);
        writeBack = 4'b0100;
        req = 4'b0010;
        drain("t_writeback", 20);
        req = '0; writeBack = '0;

        // writeBack only during BROADCAST must be ignored.
        set_cache(3, 3'b010, 8'hE1);
        push(4'b1000, 3'b010, 8'hE1, 3, 0);
        req = 4'b1000;
        k = 0;
        while (grant == 0 && k < 10) begin tick(1); k++; end
        check("t_wb_outside_grant", grant, 4'b1000);
        writeBack = 4'b0111;
        tick(1);
        writeBack = '0;
        drain("t_wb_outside", 20);
        req = '0;

        // Fairness: all four requesting, pointer at 0.
        set_cache(0, 3'b010, 8'hA0);
        set_cache(1, 3'b001, 8'hA1);
        set_cache(2, 3'b011, 8'hA2);
        set_cache(3, 3'b010, 8'hA3);
        push(4'b0001, 3'b010, 8'hA0, 3, 0);
        push(4'b0010, 3'b001, 8'hA1, 3, 0);
        push(4'b0100, 3'b011, 8'hA2, 3, 0);
        push(4'b1000, 3'b010, 8'hA3, 3, 0);
        push(4'b0001, 3'b010, 8'hA0, 3, 0);
        req = 4'b1111;
        drain("t_fair", 80);
        req = '0;

        // Illegal messages are never granted.
        set_cache(2, 3'b000, 8'h44);
        req = 4'b0100;
        expect_no_grant("t_illegal_000", 8);
        set_cache(2, 3'b111, 8'h44);
        expect_no_grant("t_illegal_111", 8);
        req = '0;

        // Illegal requester alongside a legal one: only the legal one wins.
        set_cache(1, 3'b011, 8'h21);
        push(4'b0010, 3'b011, 8'h21, 3, 0);
        req = 4'b0110;
        drain("t_mixed", 20);
        req = '0;

        // Reset during WRITEBACK after an INVALIDATE: abort, no done, ptr back to 0.
        set_cache(0, 3'b011, 8'h55);
        writeBack = 4'b0010;
        req = 4'b0001;
        k = 0;
        while (!wbActive && k < 20) begin tick(1); k++; end
        check("t_rst_wb_seen", wbActive, 1);
        reset = 1'b1;
        tick(1);
        check_idle_outputs("t_rst_abort");
        writeBack = '0;
        set_cache(3, 3'b001, 8'h9C);
        req = 4'b1001;
        tick(1);
        reset = 1'b0;
        push(4'b0001, 3'b011, 8'h55, 3, 0);
        push(4'b1000, 3'b001, 8'h9C, 3, 0);
        drain("t_rst_resume", 40);
        req = '0;

        // Owner's own writeBack bit is masked.
        set_cache(0, 3'b001, 8'h77);
        writeBack = 4'b0001;
        push(4'b0001, 3'b001, 8'h77, 3, 0);
        req = 4'b0001;
        drain("t_self_wb", 20);
        req = '0; writeBack = '0;

        tick(5);
        check_idle_outputs("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
